// File: rtl/komut_getirici_pkg.sv
// getir_pkg: types and constants shared between the fetch stage and the decoder
package getir_pkg;
  localparam int XLEN = 32;
  localparam int KOMUT_BAYT = 4;
  localparam logic [6:0] OP_R = 7'b0000001;
  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0000111;
  localparam logic [6:0] OP_B = 7'b0001111;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] komut;
  } getir_girdi_t;
  function automatic logic hizali(input logic [XLEN-1:0] a);
    return a[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/komut_getirici_fifo.sv
// komut_fifo: small synchronous FIFO of {pc, komut} entries with flush and occupancy
module komut_fifo import getir_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr_en,
  input  getir_girdi_t wr_data,
  input  logic         rd_en,
  output getir_girdi_t rd_data,
  output logic [AW:0]  count
);
  getir_girdi_t mem_q [DEPTH];
  getir_girdi_t mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic wr, rd;
  always_comb begin
    wr = wr_en && count_q != (AW+1)'(DEPTH) && !flush;
    rd = rd_en && count_q != '0;
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd);
    count_d = flush ? '0 : count_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  assign rd_data = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/komut_getirici.sv
// komut_getirici: instruction fetch stage feeding the decoder through a small FIFO
module komut_getirici import getir_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        dallan,
  input  logic [31:0] dallan_hedef,
  output logic [31:0] komut,
  output logic [31:0] komut_pc,
  output logic        komut_gecerli,
  input  logic        komut_hazir,
  output logic        hata
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [31:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic inflight_q, inflight_d, hata_q, hata_d;
  logic [AW:0] occ, yuk;
  logic pop, yonlen, wr;
  getir_girdi_t bas;
  komut_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (yonlen),
    .wr_en   (wr),
    .wr_data ({inflight_pc_q, imem_rdata}),
    .rd_en   (pop),
    .rd_data (bas),
    .count   (occ)
  );
  assign komut_gecerli = occ != '0;
  assign komut = bas.komut;
  assign komut_pc = bas.pc;
  assign imem_addr = pc_q;
  assign hata = hata_q;
  // A redirect drops the word arriving this cycle; an occupied slot plus a pending word must fit.
  always_comb begin
    pop = komut_gecerli & komut_hazir;
    yonlen = dallan & !hata_q;
    wr = inflight_q & !yonlen;
    yuk = occ + (AW+1)'(inflight_q) - (AW+1)'(pop);
    imem_req = !reset & !dallan & !hata_q & (yuk < (AW+1)'(FIFO_DEPTH));
    pc_d = (yonlen && hizali(dallan_hedef)) ? dallan_hedef
         : imem_req ? pc_q + 32'(KOMUT_BAYT) : pc_q;
    inflight_d = imem_req;
    inflight_pc_d = imem_req ? pc_q : inflight_pc_q;
    hata_d = hata_q | (yonlen & !hizali(dallan_hedef));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q <= 1'b0;
      hata_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q <= inflight_d;
      hata_q <= hata_d;
    end
  end
endmodule

// File: tb/tb_komut_getirici.sv
// tb_komut_getirici: scoreboard bench for the fetch stage against an address-derived memory
module tb_komut_getirici;
  import getir_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_req, komut_gecerli, hata;
  logic [31:0] imem_addr, komut, komut_pc;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic dallan = 1'b0, komut_hazir = 1'b1;
  logic [31:0] dallan_hedef = '0;
  always #5 clk = ~clk;
  komut_getirici dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .dallan        (dallan),
    .dallan_hedef  (dallan_hedef),
    .komut         (komut),
    .komut_pc      (komut_pc),
    .komut_gecerli (komut_gecerli),
    .komut_hazir   (komut_hazir),
    .hata          (hata)
  );
  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction
  always @(posedge clk) imem_rdata <= imem_req ? word(imem_addr) : 32'hDEAD_BEEF;
  getir_girdi_t sb [$];
  int checks = 0, failures = 0;
  logic exp_hata = 1'b0;
  logic s_req, s_val, s_hata;
  logic [31:0] s_addr, s_pc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic reload(input logic [31:0] a);
    getir_girdi_t e;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      e.pc = a + 32'(4 * i);
      e.komut = word(e.pc);
      sb.push_back(e);
    end
  endtask
  task automatic step(input logic hz, input logic dl, input logic [31:0] tgt);
    getir_girdi_t e;
    komut_hazir = hz;
    dallan = dl;
    dallan_hedef = tgt;
    @(negedge clk);
    s_req = imem_req;
    s_addr = imem_addr;
    s_val = komut_gecerli;
    s_pc = komut_pc;
    s_hata = hata;
    if (komut_gecerli && komut_hazir) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", komut_pc, e.pc);
        chk("sb_komut", komut, e.komut);
      end
    end
    if (dl && !exp_hata) begin
      if (tgt[1:0] == 2'b00) reload(tgt);
      else begin
        sb.delete();
        exp_hata = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_val", 32'(komut_gecerli), 32'd0);
    chk("rst_komut", komut, 32'h0);
    chk("rst_pc", komut_pc, 32'h0);
    chk("rst_hata", 32'(hata), 32'd0);
    reset = 1'b0;
    reload(32'h0);
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b0, '0);
      chk("seq_addr", s_addr, 32'(4 * c));
      chk("seq_req", 32'(s_req), 32'd1);
      chk("seq_val", 32'(s_val), 32'(c >= 2));
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, '0);
      chk("bp_req", 32'(s_req), 32'd0);
      chk("bp_val", 32'(s_val), 32'd1);
      chk("bp_hold_pc", s_pc, 32'h10);
    end
    repeat (4) step(1'b1, 1'b0, '0);
    repeat (2) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h40);
    chk("br_req", 32'(s_req), 32'd0);
    step(1'b1, 1'b0, '0);
    chk("br_t1_addr", s_addr, 32'h40);
    chk("br_t1_req", 32'(s_req), 32'd1);
    chk("br_t1_val", 32'(s_val), 32'd0);
    step(1'b1, 1'b0, '0);
    chk("br_t2_val", 32'(s_val), 32'd0);
    step(1'b1, 1'b0, '0);
    chk("br_t3_val", 32'(s_val), 32'd1);
    chk("br_t3_pc", s_pc, 32'h40);
    repeat (3) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b0, '0);
    chk("brpop_t1_val", 32'(s_val), 32'd0);
    step(1'b1, 1'b0, '0);
    chk("brpop_t2_val", 32'(s_val), 32'd0);
    step(1'b1, 1'b0, '0);
    chk("brpop_t3_pc", s_pc, 32'h100);
    repeat (2) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, '0);
    chk("wrap_a0", s_addr, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, '0);
    chk("wrap_a1", s_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, '0);
    chk("wrap_a2", s_addr, 32'h0000_0000);
    repeat (4) step(1'b1, 1'b0, '0);
    #1 reset = 1'b1;
    #1;
    chk("ar_req", 32'(imem_req), 32'd0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_val", 32'(komut_gecerli), 32'd0);
    chk("ar_komut", komut, 32'h0);
    chk("ar_pc", komut_pc, 32'h0);
    #1 reset = 1'b0;
    reload(32'h0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, '0);
      chk("ar_seq_addr", s_addr, 32'(4 * k));
      chk("ar_seq_val", 32'(s_val), 32'(k >= 2));
    end
    step(1'b1, 1'b1, 32'h42);
    chk("mis_req", 32'(s_req), 32'd0);
    chk("mis_hata_pre", 32'(s_hata), 32'd0);
    step(1'b1, 1'b0, '0);
    chk("mis_hata", 32'(s_hata), 32'd1);
    chk("mis_req_after", 32'(s_req), 32'd0);
    chk("mis_val", 32'(s_val), 32'd0);
    chk("mis_addr", s_addr, 32'h18);
    step(1'b1, 1'b1, 32'h80);
    chk("mis_ign_req", 32'(s_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, '0);
      chk("mis_ign_addr", s_addr, 32'h18);
      chk("mis_ign_val", 32'(s_val), 32'd0);
      chk("mis_ign_hata", 32'(s_hata), 32'd1);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_hata", 32'(hata), 32'd0);
    reset = 1'b0;
    exp_hata = 1'b0;
    reload(32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, '0);
      chk("rst2_addr", s_addr, 32'(4 * k));
      chk("rst2_val", 32'(s_val), 32'(k >= 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
